// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO.
// Signed operands are reduced to magnitudes, iterated one bit per cycle
// (shift-add for multiply, restoring division for divide), and the sign is
// restored in a final FIX cycle that also writes HI/LO.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            md_op,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2*W-1:0]       p_q;        // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]         a_raw_q;    // dividend as captured, reported on divide by zero
  logic [W-1:0]         a_mag_q;    // multiplicand magnitude
  logic [W-1:0]         b_mag_q;    // divisor magnitude
  logic                 is_div_q;
  logic                 neg_a_q;
  logic                 neg_b_q;
  logic [W-1:0]         hi_q;
  logic [W-1:0]         lo_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 a_neg_s;
  logic                 b_neg_s;
  logic [W-1:0]         a_mag_s;
  logic [W-1:0]         b_mag_s;
  logic [W:0]           mul_sum_s;
  logic [W:0]           div_shift_s;
  logic [W:0]           div_diff_s;
  logic [2*W-1:0]       p_step_s;
  logic [2*W-1:0]       prod_fix_s;
  logic [W-1:0]         fix_hi_s;
  logic [W-1:0]         fix_lo_s;

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

  // Operand magnitudes, one iteration step, and the sign-corrected result.
  always_comb begin
    a_neg_s     = ~md_op[0] & data_a[W-1];
    b_neg_s     = ~md_op[0] & data_b[W-1];
    a_mag_s     = a_neg_s ? (-data_a) : data_a;
    b_mag_s     = b_neg_s ? (-data_b) : data_b;

    mul_sum_s   = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, a_mag_q} : {(W+1){1'b0}});
    div_shift_s = {p_q[2*W-1:W], p_q[W-1]};
    div_diff_s  = div_shift_s - {1'b0, b_mag_q};

    if (is_div_q) begin
      // Remainder stays below the divisor, so a clear top bit means "fits".
      if (!div_diff_s[W]) begin
        p_step_s = {div_diff_s[W-1:0], p_q[W-2:0], 1'b1};
      end else begin
        p_step_s = {div_shift_s[W-1:0], p_q[W-2:0], 1'b0};
      end
    end else begin
      p_step_s = {mul_sum_s, p_q[W-1:1]};
    end

    prod_fix_s = (neg_a_q ^ neg_b_q) ? (-p_q) : p_q;

    if (!is_div_q) begin
      fix_hi_s = prod_fix_s[2*W-1:W];
      fix_lo_s = prod_fix_s[W-1:0];
    end else if (b_mag_q == {W{1'b0}}) begin
      fix_hi_s = a_raw_q;
      fix_lo_s = {W{1'b1}};
    end else begin
      // Quotient truncates toward zero; remainder follows the dividend sign.
      fix_hi_s = neg_a_q ? (-p_q[2*W-1:W]) : p_q[2*W-1:W];
      fix_lo_s = (neg_a_q ^ neg_b_q) ? (-p_q[W-1:0]) : p_q[W-1:0];
    end
  end

  // Control FSM, operand capture, iteration state and HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_WIDTH{1'b0}};
      p_q      <= {(2*W){1'b0}};
      a_raw_q  <= {W{1'b0}};
      a_mag_q  <= {W{1'b0}};
      b_mag_q  <= {W{1'b0}};
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= {W{1'b0}};
      lo_q     <= {W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start && !md_op[2]) begin
            state_q  <= ST_CALC;
            busy_q   <= 1'b1;
            cnt_q    <= {CNT_WIDTH{1'b0}};
            a_raw_q  <= data_a;
            a_mag_q  <= a_mag_s;
            b_mag_q  <= b_mag_s;
            is_div_q <= md_op[1];
            neg_a_q  <= a_neg_s;
            neg_b_q  <= b_neg_s;
            p_q      <= md_op[1] ? {{W{1'b0}}, a_mag_s} : {{W{1'b0}}, b_mag_s};
          end else if (start && (md_op == 3'b100)) begin
            hi_q <= data_a;
          end else if (start && (md_op == 3'b101)) begin
            lo_q <= data_a;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          p_q   <= p_step_s;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_FIX;
          end else begin
            state_q <= ST_CALC;
          end
        end
        ST_FIX: begin
          hi_q    <= fix_hi_s;
          lo_q    <= fix_lo_s;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers; executes MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Sits beside the single-cycle ALU in the EX stage.
- Asserts busy so the hazard unit can stall dependent MFHI/MFLO and new mult/div issues.
- Successor to the combinational ALU: width-generic, multi-cycle, and stateful.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width W; even, >= 4
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe, sampled on the rising edge
- md_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved
- data_a  in  W  multiplicand/dividend; source for MTHI/MTLO
- data_b  in  W  multiplier/divisor
- hi  out  W  HI register
- lo  out  W  LO register
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when HI/LO receive a mult/div result

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset: hi=0, lo=0, busy=0, done=0, FSM=IDLE. Reset asserted mid-operation aborts it; no partial result is written.
- FSM states:
  - IDLE: busy=0.
  - CALC: W iterations, one bit per cycle.
  - FIX: sign correction and result write.
- Transitions:
  - IDLE -> CALC on start with md_op in {000..011}.
  - CALC -> FIX when the counter reaches W-1.
  - FIX -> IDLE unconditionally.
- busy = (state != IDLE).
- Latency: a start accepted at edge E0 writes hi/lo at edge E0+W+1. done=1 for exactly the cycle following that edge; busy is already 0 in that cycle.
- Issue rules:
  - A start in the done cycle is accepted (back-to-back issue).
  - start while busy is ignored entirely; no queuing, no corruption.
  - Operands are captured at acceptance; later changes to data_a/data_b have no effect.
- MTHI/MTLO:
  - Accepted only in IDLE.
  - Written at the next edge (hi<=data_a or lo<=data_a); no busy, no done.
  - Ignored while busy.
- Reserved md_op values are ignored.
- Signed handling:
  - Operands are converted to magnitudes and iterated unsigned.
  - FIX negates results as required.
  - The MSB is the sign bit for MULT/DIV only.
- MULT/MULTU: 2W-bit product; hi = upper W bits, lo = lower W bits.
- DIV/DIVU:
  - lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- Divide by zero (DIV or DIVU): lo = all ones, hi = data_a as captured. Full latency still applies.
- hi/lo hold their value between writes and are readable in any state. During CALC they show the previous architectural value, not intermediates.

Test Plan:
- W=32, MULT a=-3, b=5 -> after W+1 cycles: done pulse, hi=FFFFFFFF, lo=FFFFFFF1; busy high for exactly 33 cycles.
- W=32, MULTU a=FFFFFFFF, b=2 -> hi=00000001, lo=FFFFFFFE. Then DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- W=32 boundaries:
  - DIVU a=7, b=0 -> lo=FFFFFFFF, hi=00000007.
  - DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- W=32, MULT 4*4 with a second start (DIVU 9/2) 5 cycles later -> second start ignored; hi=0, lo=10. Back-to-back DIVU 9/2 issued in the done cycle -> lo=4, hi=1.
- W=32, MTHI a=12345678 in IDLE -> hi=12345678 next cycle. MTLO while busy -> lo unchanged. Reset at CALC cycle 10 -> hi=lo=0, busy=0, no done pulse.
- W=8 instance:
  - MULT 80*80 -> hi=40, lo=00.
  - DIVU FF/10 -> lo=0F, hi=0F.
  - done after 9 cycles.
